// File: rtl/mult_operand_fifo_pkg.sv
// Shared constants and sizing helper for the multiplier operand-pair FIFO.
// Pure definitions; no logic, latency or flow control of its own.
package mult_operand_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Bits needed to encode values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_operand_fifo_if.sv
// Operand-pair push/pop bus between the producer, the FIFO and the multiplier controller.
// Optional ovf/udf error flags appear only when MULT_OPERAND_FIFO_ERR_EN is defined.
interface mult_operand_fifo_if
    import mult_operand_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ld_mult;
    logic             full;
    logic             can_mult;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [CNT_W-1:0] count;
`ifdef MULT_OPERAND_FIFO_ERR_EN
    logic             ovf;
    logic             udf;

    modport master (
        output flush, wr_en, a_in, b_in, ld_mult,
        input  full, can_mult, a_out, b_out, count, ovf, udf
    );
    modport slave (
        input  flush, wr_en, a_in, b_in, ld_mult,
        output full, can_mult, a_out, b_out, count, ovf, udf
    );
`else
    modport master (
        output flush, wr_en, a_in, b_in, ld_mult,
        input  full, can_mult, a_out, b_out, count
    );
    modport slave (
        input  flush, wr_en, a_in, b_in, ld_mult,
        output full, can_mult, a_out, b_out, count
    );
`endif

endinterface

// File: rtl/mult_operand_fifo_operand_pair_ram.sv
// DEPTH x 2*WIDTH operand-pair storage: synchronous write, asynchronous read.
// Write lands on the clock edge; read data follows raddr combinationally; no flow control.
module operand_pair_ram
    import mult_operand_fifo_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PTR_W = clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTR_W-1:0]   waddr,
    input  logic [2*WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]   raddr,
    output logic [2*WIDTH-1:0] rdata
);

    logic [2*WIDTH-1:0] mem [DEPTH];

    // Contents are intentionally not reset; the FIFO masks stale entries by count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mult_operand_fifo.sv
// First-word-fall-through operand-pair FIFO feeding the multiplier; 1-cycle write-to-read latency.
// Pushes to a full FIFO drop unless a pop shares the cycle; sticky ovf/udf under MULT_OPERAND_FIFO_ERR_EN.
module mult_operand_fifo
    import mult_operand_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    mult_operand_fifo_if.slave bus
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   occ;
    logic               push_ok;
    logic               pop_ok;
    logic [2*WIDTH-1:0] rd_pair;

    // A pop frees the slot the same-cycle push needs, so full+push+pop is legal.
    assign pop_ok  = bus.ld_mult && (occ != '0);
    assign push_ok = bus.wr_en && ((occ != FULL_CNT) || pop_ok);

    // DEPTH is a power of two, so natural pointer overflow wraps DEPTH-1 to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    operand_pair_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok && !bus.flush),
        .waddr (wr_ptr),
        .wdata ({bus.a_in, bus.b_in}),
        .raddr (rd_ptr),
        .rdata (rd_pair)
    );

    assign bus.count    = occ;
    assign bus.can_mult = (occ != '0);
    assign bus.full     = (occ == FULL_CNT);
    assign bus.a_out    = (occ != '0) ? rd_pair[2*WIDTH-1:WIDTH] : '0;
    assign bus.b_out    = (occ != '0) ? rd_pair[WIDTH-1:0]       : '0;

`ifdef MULT_OPERAND_FIFO_ERR_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (bus.flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.wr_en && !push_ok) begin
                ovf_q <= 1'b1;
            end
            if (bus.ld_mult && !pop_ok) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.udf = udf_q;
`endif

endmodule

// File: doc/mult_operand_fifo.md
MULT_OPERAND_FIFO -- requirements
Module: mult_operand_fifo

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 4, giving the number of operand-pair entries; legal values are powers of two, 2 or more.
REQ-003 clk  input  1  clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous clear of all buffered pairs.
REQ-006 wr_en  input  1  push request for the pair {a_in, b_in}.
REQ-007 a_in  input  WIDTH  operand A to push.
REQ-008 b_in  input  WIDTH  operand B to push.
REQ-009 ld_mult  input  1  pop request from the downstream pipeline controller.
REQ-010 full  output  1  high when DEPTH pairs are held.
REQ-011 can_mult  output  1  high when at least one pair is held; feeds the downstream controller's can_mult.
REQ-012 a_out  output  WIDTH  head operand A (first-word-fall-through).
REQ-013 b_out  output  WIDTH  head operand B.
REQ-014 count  output  clog2(DEPTH+1)  number of pairs held.

Function
REQ-015 Storage SHALL be a circular buffer with write pointer, read pointer and occupancy count; pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 A push SHALL be accepted when wr_en=1 and either count<DEPTH or a pop is accepted in the same cycle.
REQ-017 A pop SHALL be accepted when ld_mult=1 and count>0.
REQ-018 A push request that is not accepted SHALL be dropped, with no state change.
REQ-019 A pop request that is not accepted SHALL be ignored, with no state change.
REQ-020 When count=0, a simultaneous push and pop SHALL accept the push only; count becomes 1.
REQ-021 When count=DEPTH, a simultaneous push and pop SHALL accept both; count stays DEPTH and both pointers advance.
REQ-022 flush=1 SHALL zero both pointers and count on the next edge, with priority over push and pop in that cycle.
REQ-023 can_mult SHALL equal (count!=0), and full SHALL equal (count==DEPTH); both are derived from registered count with no combinational path from the inputs.
REQ-024 a_out/b_out SHALL show the entry at the read pointer when count>0, and 0 when count=0.
REQ-025 Pushed data SHALL be visible at a_out/b_out no earlier than the cycle after the push (one-cycle write-to-read latency).
REQ-026 An accepted pop SHALL present the next entry on the following cycle.
REQ-027 Pairs SHALL leave in strict push order, and A/B SHALL never be split across entries.

Reset
REQ-028 rst=1 SHALL asynchronously clear the pointers and count to 0, giving full=0, can_mult=0, a_out=0 and b_out=0.
REQ-029 Storage array contents SHALL NOT be reset.
REQ-030 Reset asserted mid-operation SHALL discard all buffered pairs.

Configuration
REQ-031 With macro MULT_OPERAND_FIFO_ERR_EN defined, the block SHALL add outputs ovf and udf (1 bit each), reset to 0.
REQ-032 Under MULT_OPERAND_FIFO_ERR_EN, ovf SHALL set sticky on a dropped push, udf SHALL set sticky on an ignored pop, and both SHALL clear only on rst or flush.
REQ-033 Without MULT_OPERAND_FIFO_ERR_EN, the ovf/udf ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 The shared package SHALL hold the default WIDTH/DEPTH constants and the pointer/count width function (clog2).
REQ-035 The block SHALL instantiate one sub-module, operand_pair_ram: a DEPTH x 2*WIDTH register array with a synchronous write port and an asynchronous read port.

Verification
REQ-036 Bench: assert rst for 2 cycles, then release -> count=0, can_mult=0, full=0, a_out=0, b_out=0.
REQ-037 Bench: push (3,5),(7,2),(1,1),(9,4) with DEPTH=4 -> full=1, count=4, a_out=3, b_out=5; then push (8,8) -> dropped, ovf=1 when MULT_OPERAND_FIFO_ERR_EN is defined.
REQ-038 Bench: hold ld_mult=1 for 4 cycles -> heads seen in order (3,5),(7,2),(1,1),(9,4), then can_mult=0; a fifth pop -> ignored, udf=1 when MULT_OPERAND_FIFO_ERR_EN is defined.
REQ-039 Bench: while full, assert wr_en and ld_mult together with (6,6) -> count stays 4 and (6,6) emerges last after the pointer wrap.
REQ-040 Bench: while empty, assert wr_en and ld_mult together with (2,3) -> count=1 and a_out=2 on the next cycle.
REQ-041 Bench: with 3 pairs held, assert flush together with wr_en -> count=0 and can_mult=0 next cycle, and the push is not stored.
